// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [InstW-1:0]     inst_t;

  localparam inst_t      ZeroWord    = 32'h0000_0000;
  localparam inst_addr_t ResetVector = 32'h0000_0000;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [0:0] {
    FetchState = 1'b0,
    HoldState  = 1'b1
  } fetch_state_e;

  function automatic inst_addr_t seq_pc(input inst_addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : MIPS IF stage - owns the PC, fetches over a req/ack bus and
//                handles stalls, delayed branches and flush redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = ResetVector
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       stall_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  input  logic             flush_i,
  input  logic [31:0]      new_pc_i,
  output logic             inst_req_o,
  output logic [31:0]      inst_addr_o,
  input  logic             inst_ack_i,
  input  logic [31:0]      inst_rdata_i,
  output logic [31:0]      if_pc_o,
  output logic [31:0]      if_inst_o,
  output logic             stallreq_if_o
);

  fetch_state_e state_q, state_d;
  inst_addr_t   pc_q, pc_d;
  inst_addr_t   br_tgt_q, br_tgt_d;
  inst_addr_t   kill_tgt_q, kill_tgt_d;
  inst_t        buf_q, buf_d;
  logic         br_pend_q, br_pend_d;
  logic         kill_q, kill_d;
  logic         run_q;

  logic         w_in_fetch;
  logic         w_req;
  logic         w_ack;
  logic         w_good;
  logic         w_go;
  logic         w_pend_eff;
  inst_addr_t   w_tgt_eff;
  inst_addr_t   w_next_pc;
  logic         w_unused_stall;

  // run_q keeps the bus idle until the first edge after reset release.
  assign w_in_fetch = (state_q == FetchState);
  assign w_req      = run_q & w_in_fetch;
  assign w_ack      = w_req & inst_ack_i;
  assign w_good     = w_ack & ~kill_q;
  assign w_go       = (stall_i[0] == NoStop);

  // A branch arriving in the same cycle as the delay slot completes steers
  // the very next fetch, so the pending state is merged with the live pulse.
  assign w_pend_eff = br_pend_q | branch_flag_i;
  assign w_tgt_eff  = branch_flag_i ? branch_target_i : br_tgt_q;
  assign w_next_pc  = w_pend_eff ? w_tgt_eff : seq_pc(pc_q);

  assign w_unused_stall = ^stall_i[5:1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    kill_d     = kill_q;
    kill_tgt_d = kill_tgt_q;
    if (run_q) begin
      if (flush_i) begin
        br_pend_d = 1'b0;
        if (w_in_fetch && !w_ack) begin
          kill_d     = 1'b1;
          kill_tgt_d = new_pc_i;
        end else begin
          pc_d    = new_pc_i;
          state_d = FetchState;
          kill_d  = 1'b0;
        end
      end else begin
        br_pend_d = w_pend_eff;
        br_tgt_d  = w_tgt_eff;
        if (w_in_fetch) begin
          if (w_ack && kill_q) begin
            pc_d   = kill_tgt_q;
            kill_d = 1'b0;
          end else if (w_good && w_go) begin
            pc_d      = w_next_pc;
            br_pend_d = 1'b0;
          end else if (w_good) begin
            buf_d   = inst_rdata_i;
            state_d = HoldState;
          end
        end else if (w_go) begin
          pc_d      = w_next_pc;
          br_pend_d = 1'b0;
          state_d   = FetchState;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FetchState;
      pc_q       <= RESET_PC;
      buf_q      <= ZeroWord;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= RESET_PC;
      kill_q     <= 1'b0;
      kill_tgt_q <= RESET_PC;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
      kill_q     <= kill_d;
      kill_tgt_q <= kill_tgt_d;
      run_q      <= 1'b1;
    end
  end

  assign inst_req_o    = w_req;
  assign inst_addr_o   = pc_q;
  assign if_pc_o       = pc_q;
  assign if_inst_o     = w_in_fetch ? (w_good ? inst_rdata_i : ZeroWord) : buf_q;
  assign stallreq_if_o = w_req & ~w_good;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Self-checking bench for if_fetch with a wait-state memory
//                and an instruction-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int          tests_run;
  int          tests_failed;

  bit          outstanding;
  bit          cont;
  int          remaining;
  logic [31:0] req_addr;
  logic [31:0] mem_key;
  int          mem_minw;
  int          mem_maxw;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .stall_i         (stall),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .flush_i         (flush),
    .new_pc_i        (new_pc),
    .inst_req_o      (inst_req),
    .inst_addr_o     (inst_addr),
    .inst_ack_i      (inst_ack),
    .inst_rdata_i    (inst_rdata),
    .if_pc_o         (if_pc),
    .if_inst_o       (if_inst),
    .stallreq_if_o   (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, clear pulses, and let the
  // memory model answer the request now on the bus.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    branch_flag = 1'b0;
    flush       = 1'b0;
    cont        = 1'b0;
    if (inst_req && !outstanding) begin
      outstanding = 1'b1;
      remaining   = int'($urandom_range(mem_maxw, mem_minw));
      req_addr    = inst_addr;
    end else if (outstanding) begin
      cont = 1'b1;
    end
    if (outstanding) begin
      if (remaining == 0) begin
        inst_ack    = 1'b1;
        inst_rdata  = req_addr ^ mem_key;
        outstanding = 1'b0;
      end else begin
        inst_ack   = 1'b0;
        inst_rdata = $urandom;
        remaining--;
      end
    end else begin
      inst_ack   = 1'b0;
      inst_rdata = $urandom;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    inst_ack    = 1'b0;
    outstanding = 1'b0;
    stall       = 6'd0;
    branch_flag = 1'b0;
    flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h5555_0000;
    @(posedge clk);
    #1;
    rst_n = 1'b0; inst_ack = 1'b1; inst_rdata = 32'hDEAD_BEEF; outstanding = 1'b0;
    #2;
    tests_run++;
    if ({inst_req, inst_addr, if_pc, if_inst, stallreq_if} !== {1'b0, RST_PC, RST_PC, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: req=%b addr=%h pc=%h inst=%h stallreq=%b, want 0/%h/%h/0/0",
               inst_req, inst_addr, if_pc, if_inst, stallreq_if, RST_PC, RST_PC);
    end
    repeat (2) @(posedge clk);
    #3;
    tests_run++;
    if ({inst_req, if_inst, stallreq_if} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_held: req=%b inst=%h stallreq=%b, want 0/0/0", inst_req, if_inst, stallreq_if);
    end
    inst_ack = 1'b0;
    rst_n    = 1'b1;
    #1;
    tests_run++;
    if (inst_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: req=%b, want 0", inst_req);
    end
    next_cycle();
    #2;
    tests_run++;
    if ({inst_req, inst_addr, if_inst, stallreq_if} !== {1'b1, RST_PC, RST_PC ^ mem_key, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: req=%b addr=%h inst=%h stallreq=%b, want 1/%h/%h/0",
               inst_req, inst_addr, if_inst, stallreq_if, RST_PC, RST_PC ^ mem_key);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      #2;
      a = 32'(4 * i);
      tests_run++;
      if ({inst_req, inst_addr, if_pc, if_inst, stallreq_if} !== {1'b1, a, a, a, 1'b0}) begin
        tests_failed++;
        $display("FAIL zero_wait[%0d]: req=%b addr=%h pc=%h inst=%h stallreq=%b, want 1/%h/%h/%h/0",
                 i, inst_req, inst_addr, if_pc, if_inst, stallreq_if, a, a, a);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a, ei;
    logic        es;
    mem_minw = 2; mem_maxw = 2; mem_key = 32'hA5A5_0000;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 3; w++) begin
        next_cycle();
        #2;
        a  = 32'(4 * f);
        ei = (w == 2) ? (a ^ mem_key) : 32'h0;
        es = (w != 2);
        tests_run++;
        if ({inst_req, inst_addr, if_inst, stallreq_if} !== {1'b1, a, ei, es}) begin
          tests_failed++;
          $display("FAIL wait_states[%0d.%0d]: req=%b addr=%h inst=%h stallreq=%b, want 1/%h/%h/%b",
                   f, w, inst_req, inst_addr, if_inst, stallreq_if, a, ei, es);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] d4;
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h3C3C_0000;
    d4 = 32'h4 ^ mem_key;
    apply_reset();
    next_cycle();
    next_cycle();
    stall = 6'b000001;
    #2;
    tests_run++;
    if ({inst_req, inst_addr, if_inst, stallreq_if} !== {1'b1, 32'h4, d4, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_capture: req=%b addr=%h inst=%h stallreq=%b, want 1/4/%h/0",
               inst_req, inst_addr, if_inst, stallreq_if, d4);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      if (k == 2) stall = 6'd0;
      #2;
      tests_run++;
      if ({inst_req, if_pc, if_inst, stallreq_if} !== {1'b0, 32'h4, d4, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_state[%0d]: req=%b pc=%h inst=%h stallreq=%b, want 0/4/%h/0",
                 k, inst_req, if_pc, if_inst, stallreq_if, d4);
      end
    end
    next_cycle();
    #2;
    tests_run++;
    if ({inst_req, inst_addr, if_inst} !== {1'b1, 32'h8, 32'h8 ^ mem_key}) begin
      tests_failed++;
      $display("FAIL hold_release: req=%b addr=%h inst=%h, want 1/8/%h",
               inst_req, inst_addr, if_inst, 32'h8 ^ mem_key);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ea [6];
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h0F0F_0000;
    ea = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin mem_minw = 2; mem_maxw = 2; end
      next_cycle();
      if (i == 2) begin branch_flag = 1'b1; branch_target = 32'h100; end
      if (i == 5) begin branch_flag = 1'b1; branch_target = 32'h200; end
      #2;
      tests_run++;
      if ({inst_addr, if_pc} !== {ea[i], ea[i]}) begin
        tests_failed++;
        $display("FAIL branch_seq[%0d]: addr=%h pc=%h, want %h", i, inst_addr, if_pc, ea[i]);
      end
    end
    next_cycle();
    branch_flag = 1'b1; branch_target = 32'h240;
    mem_minw = 0; mem_maxw = 0;
    next_cycle();
    #2;
    tests_run++;
    if ({inst_addr, if_inst, stallreq_if} !== {32'h108, 32'h108 ^ mem_key, 1'b0}) begin
      tests_failed++;
      $display("FAIL branch_delay_slot: addr=%h inst=%h stallreq=%b, want 108/%h/0",
               inst_addr, if_inst, stallreq_if, 32'h108 ^ mem_key);
    end
    next_cycle();
    #2;
    tests_run++;
    if (inst_addr !== 32'h240) begin
      tests_failed++;
      $display("FAIL branch_overwrite: addr=%h, want 240", inst_addr);
    end
  endtask

  task automatic test_flush();
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h7777_0000;
    apply_reset();
    repeat (8) next_cycle();
    mem_minw = 3; mem_maxw = 3;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin mem_minw = 0; mem_maxw = 0; end
      next_cycle();
      if (k == 0) begin flush = 1'b1; new_pc = 32'h180; end
      #2;
      tests_run++;
      if ({inst_req, inst_addr, if_inst, stallreq_if} !== {1'b1, 32'h20, 32'h0, 1'b1}) begin
        tests_failed++;
        $display("FAIL flush_kill[%0d]: req=%b addr=%h inst=%h stallreq=%b, want 1/20/0/1",
                 k, inst_req, inst_addr, if_inst, stallreq_if);
      end
    end
    next_cycle();
    flush = 1'b1; new_pc = 32'h200;
    branch_flag = 1'b1; branch_target = 32'h300;
    #2;
    tests_run++;
    if ({inst_addr, if_inst} !== {32'h180, 32'h180 ^ mem_key}) begin
      tests_failed++;
      $display("FAIL flush_redirect: addr=%h inst=%h, want 180/%h", inst_addr, if_inst, 32'h180 ^ mem_key);
    end
    next_cycle();
    #2;
    tests_run++;
    if (inst_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL flush_over_branch: addr=%h, want 200", inst_addr);
    end
    next_cycle();
    #2;
    tests_run++;
    if (inst_addr !== 32'h204) begin
      tests_failed++;
      $display("FAIL flush_branch_dropped: addr=%h, want 204", inst_addr);
    end
  endtask

  task automatic test_reset_mid();
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h0;
    apply_reset();
    repeat (3) next_cycle();
    mem_minw = 3; mem_maxw = 3;
    next_cycle();
    next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({inst_req, inst_addr, if_pc, if_inst, stallreq_if} !== {1'b0, RST_PC, RST_PC, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid: req=%b addr=%h pc=%h inst=%h stallreq=%b, want 0/%h/%h/0/0",
               inst_req, inst_addr, if_pc, if_inst, stallreq_if, RST_PC, RST_PC);
    end
    outstanding = 1'b0; inst_ack = 1'b0;
    mem_minw = 0; mem_maxw = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
    #2;
    tests_run++;
    if ({inst_req, inst_addr, if_inst, stallreq_if} !== {1'b1, RST_PC, RST_PC, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_restart: req=%b addr=%h inst=%h stallreq=%b, want 1/%h/%h/0",
               inst_req, inst_addr, if_inst, stallreq_if, RST_PC, RST_PC);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    mem_minw = 0; mem_maxw = 0; mem_key = 32'h1111_0000;
    ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    apply_reset();
    next_cycle();
    flush = 1'b1; new_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #2;
      tests_run++;
      if ({inst_addr, if_inst} !== {ea[i], ea[i] ^ mem_key}) begin
        tests_failed++;
        $display("FAIL pc_wrap[%0d]: addr=%h inst=%h, want %h/%h", i, inst_addr, if_inst, ea[i], ea[i] ^ mem_key);
      end
    end
  endtask

  // Instruction-level model: each delivered instruction must be the next one
  // in program order; a branch makes the instruction after the current one
  // the target, and a flush restarts the stream at new_pc.
  task automatic test_random();
    logic [31:0] exp_pc, tgt, r;
    bit          pend;
    int          consumed;
    mem_minw = 0; mem_maxw = 3; mem_key = $urandom;
    apply_reset();
    exp_pc = RST_PC; pend = 1'b0; tgt = 32'h0; consumed = 0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      r = $urandom;
      stall = {r[7:3], (r[1:0] == 2'b00)};
      branch_flag   = (r[11:8] == 4'h0);
      branch_target = $urandom & 32'hFFFF_FFFC;
      flush         = (r[16:12] == 5'h00);
      new_pc        = $urandom & 32'hFFFF_FFFC;
      #2;
      if (cont) begin
        tests_run++;
        if ({inst_req, inst_addr} !== {1'b1, req_addr}) begin
          tests_failed++;
          $display("FAIL bus_hold[%0d]: req=%b addr=%h, want 1/%h", n, inst_req, inst_addr, req_addr);
        end
      end
      if (flush) begin
        exp_pc = new_pc;
        pend   = 1'b0;
      end else begin
        if (branch_flag) begin
          pend = 1'b1;
          tgt  = branch_target;
        end
        if (!stallreq_if && !stall[0]) begin
          tests_run++;
          if ({if_pc, if_inst} !== {exp_pc, exp_pc ^ mem_key}) begin
            tests_failed++;
            $display("FAIL stream[%0d]: pc=%h inst=%h, want %h/%h", n, if_pc, if_inst, exp_pc, exp_pc ^ mem_key);
          end
          consumed++;
          exp_pc = pend ? tgt : exp_pc + 32'd4;
          pend   = 1'b0;
        end
      end
    end
    tests_run++;
    if (consumed < 300) begin
      tests_failed++;
      $display("FAIL stream_progress: delivered %0d instructions, want at least 300", consumed);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; stall = 6'd0; branch_flag = 1'b0; branch_target = 32'h0;
    flush = 1'b0; new_pc = 32'h0; inst_ack = 1'b0; inst_rdata = 32'h0;
    outstanding = 1'b0; cont = 1'b0; remaining = 0; req_addr = 32'h0;
    mem_key = 32'h0; mem_minw = 0; mem_maxw = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold();
    test_branch();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS core, directly upstream of the IF/ID pipeline register. Owns the program counter, issues word reads to instruction memory over a req/ack bus, and presents `if_pc`/`if_inst` to IF/ID. Honours the `stall` vector from the pipeline controller, raises a stall request while memory is busy, takes delayed-slot branch redirects from ID, and takes exception/flush redirects that cancel the in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall`  in  6  controller stall vector; bit 0 freezes PC/fetch (`Stop`/`NoStop` encoding)
- `branch_flag`  in  1  ID resolved a taken branch/jump; one-cycle pulse
- `branch_target`  in  32  target for `branch_flag`
- `flush`  in  1  exception/eret redirect; one-cycle pulse
- `new_pc`  in  32  target for `flush`
- `inst_req`  out  1  memory read request
- `inst_addr`  out  32  word address of request
- `inst_ack`  in  1  read complete this cycle
- `inst_rdata`  in  32  instruction, valid only with `inst_ack`
- `if_pc`  out  32  PC of presented instruction
- `if_inst`  out  32  presented instruction; `ZeroWord` (NOP) when none
- `stallreq_if`  out  1  fetch not ready; controller must stall

## Operation
- Registers: `pc`, `state` {FETCH, HOLD}, `buf_inst`, `br_pend`/`br_tgt`, `kill`/`kill_tgt`.
- FETCH: `inst_req`=1, `inst_addr`=`pc`. `if_pc`=`pc`; `if_inst`=`inst_rdata` when `inst_ack` & !`kill`, else 0. `stallreq_if` = !(`inst_ack` & !`kill`).
  - Ack, !kill, `stall[0]`=NoStop: `pc`<=next_pc; stay FETCH.
  - Ack, !kill, `stall[0]`=Stop: `buf_inst`<=`inst_rdata`; go HOLD.
  - Ack, kill: data discarded; `pc`<=`kill_tgt`, clear `kill`; stay FETCH.
- HOLD: `inst_req`=0; `if_inst`=`buf_inst`, `if_pc`=`pc`, `stallreq_if`=0. On `stall[0]`=NoStop: `pc`<=next_pc; go FETCH.
- next_pc = `br_tgt` if `br_pend` (clear `br_pend`), else `pc`+4 (mod 2^32, wraps silently).
- `branch_flag`: sets `br_pend`, `br_tgt`. The current fetch is the delay slot and completes normally. A second `branch_flag` while `br_pend` overwrites the target.
- `flush` (highest priority, overrides `branch_flag` same cycle): clears `br_pend`.
  - FETCH without ack this cycle: `kill`<=1, `kill_tgt`<=`new_pc`.
  - FETCH with ack this cycle, or HOLD: `pc`<=`new_pc`, go FETCH, `kill`<=0.
  - During `kill`, further `flush` only updates `kill_tgt`.
- Bus rule: once `inst_req` is asserted, `inst_req` and `inst_addr` stay constant until the ack cycle. Requests are never withdrawn. A zero-wait ack in the first req cycle is legal.

## Timing
- Reset (async assert): `pc`=`RESET_PC`, state FETCH, `br_pend`=`kill`=0, `buf_inst`=0.
- Outputs during reset: `inst_req`=0, `inst_addr`=`RESET_PC`, `if_pc`=`RESET_PC`, `if_inst`=0, `stallreq_if`=0.
- `inst_req` rises on the first edge after `rst` deasserts.
- `if_pc`/`if_inst` are combinational from state and bus in FETCH, and registered in HOLD.
- Throughput: one instruction per cycle with zero-wait memory. N wait cycles add N stall cycles.
- `branch_flag` affects the fetch after the one in flight, at the earliest the next address.
- `flush` with a pending fetch: the first redirected `inst_addr` appears the cycle after the killed ack.
- Reset mid-request: all state is dropped. The memory must tolerate abandonment only under reset.

## Structure
- Add to `defines.v`: `ResetVector`, fetch state encodings `FetchState`/`HoldState`. Reuse `InstAddrBus`, `InstBus`, `ZeroWord`, `Stop`/`NoStop`.
- Single module, no sub-module. The next-PC mux stays inline.

## Test plan
- Reset, then zero-wait memory returning addr as data, no stalls: `inst_addr` 0,4,8,… one per cycle. `if_inst`=addr. `stallreq_if` stays 0.
- Memory with 2 wait cycles: `stallreq_if`=1 for 2 cycles per fetch. `inst_addr` held stable. `if_inst`=0 until ack.
- Ack while `stall[0]`=Stop for 3 cycles: HOLD, `inst_req`=0, `if_inst` held at captured word. On release, next `inst_addr`=`pc`+4.
- `branch_flag` with target 0x100 while fetching 0x8: 0x8 completes (delay slot), next `inst_addr`=0x100.
- `flush`, `new_pc`=0x180, mid 3-wait fetch of 0x20: ack data discarded, `if_inst`=0, next `inst_addr`=0x180. `flush`+`branch_flag` same cycle: flush wins.
- `rst` asserted during outstanding request: outputs go to reset values immediately. After release, fetch restarts at `RESET_PC`. PC 0xFFFFFFFC wraps to 0.
